s_axis_cc_adapt_x8: RTL and testbench

- Completer-completion (CC) adapter for the UltraScale+ Gen3 x8 PHY wrapper, 256-bit datapath; the reverse direction of the CQ adapter.
- Accepts legacy 3DW-header completion TLPs (Cpl/CplD/CplLk/CplDLk) from the core's TLP layer and rewrites the first-beat header into the IP's 96-bit CC descriptor.
- Converts byte keep to dword keep, checks payload length, and drives the IP's s_axis_cc interface through a registered skid buffer.

---
 rtl/litepcie_usp_pkg.sv | 102 ++++++++++
 rtl/axis_skid_buf.sv | 84 ++++++++
 rtl/s_axis_cc_adapt_x8.sv | 159 +++++++++++++++
 tb/tb_s_axis_cc_adapt_x8.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/litepcie_usp_pkg.sv
// ============================================================================
//  Module      : litepcie_usp_pkg
//  Description : Shared definitions for the UltraScale+ PCIe adapters.
//                - Legacy 3DW TLP header field offsets (shared with CQ).
//                - CC descriptor field offsets.
//                - Completion TLP type constants and status encodings.
//                - Helpers that rewrite a completion header into a CC
//                  descriptor.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package litepcie_usp_pkg;

  // Legacy header field offsets, as bit positions in the first 96 bits.
  localparam int LEG_LEN_LSB    = 0;   // DW0 length[9:0]
  localparam int LEG_ATTR_LSB   = 12;  // DW0 attr[13:12]
  localparam int LEG_EP_BIT     = 14;  // DW0 poisoned
  localparam int LEG_ATTR2_BIT  = 18;  // DW0 ID-based ordering
  localparam int LEG_TC_LSB     = 20;  // DW0 traffic class
  localparam int LEG_TYPE_LSB   = 24;  // DW0 type[4:0]
  localparam int LEG_FMT_LSB    = 29;  // DW0 fmt[2:0]
  localparam int LEG_BC_LSB     = 32;  // DW1 byte count[11:0]
  localparam int LEG_STATUS_LSB = 45;  // DW1 completion status
  localparam int LEG_CID_LSB    = 48;  // DW1 completer ID
  localparam int LEG_LADDR_LSB  = 64;  // DW2 lower address[6:0]
  localparam int LEG_TAG_LSB    = 72;  // DW2 tag
  localparam int LEG_RID_LSB    = 80;  // DW2 requester ID

  // CC descriptor field offsets.
  localparam int CC_LADDR_LSB   = 0;
  localparam int CC_BC_LSB      = 16;
  localparam int CC_LOCKED_BIT  = 29;
  localparam int CC_DWCNT_LSB   = 32;
  localparam int CC_STATUS_LSB  = 43;
  localparam int CC_EP_BIT      = 46;
  localparam int CC_RID_LSB     = 48;
  localparam int CC_TAG_LSB     = 64;
  localparam int CC_CID_LO_LSB  = 72;
  localparam int CC_CID_HI_LSB  = 80;
  localparam int CC_TC_LSB      = 89;
  localparam int CC_ATTR_LSB    = 92;

  // Number of header dwords in a legacy completion TLP.
  localparam logic [10:0] LEG_HDR_DWORDS = 11'd3;

  localparam logic [4:0] TLP_TYPE_CPL    = 5'b01010;
  localparam logic [4:0] TLP_TYPE_CPL_LK = 5'b01011;

  typedef enum logic [2:0] {
    CPL_STATUS_SC  = 3'b000,
    CPL_STATUS_UR  = 3'b001,
    CPL_STATUS_CRS = 3'b010,
    CPL_STATUS_CA  = 3'b100
  } cpl_status_e;

  // Payload dwords announced by a completion header; no-data completions
  // (fmt[1]=0) carry none, and a length field of 0 encodes 1024.
  function automatic logic [10:0] cc_dword_count(input logic [95:0] hdr);
    logic [9:0] len;
    len = hdr[LEG_LEN_LSB +: 10];
    if (!hdr[LEG_FMT_LSB + 1]) begin
      return 11'd0;
    end
    return (len == 10'd0) ? 11'd1024 : {1'b0, len};
  endfunction

  // Rewrite a legacy 3DW completion header into the 96-bit CC descriptor.
  function automatic logic [95:0] cc_build_desc(input logic [95:0] hdr);
    logic [95:0] d;
    logic [11:0] bc;
    d  = '0;
    bc = hdr[LEG_BC_LSB +: 12];
    d[CC_LADDR_LSB +: 7]  = hdr[LEG_LADDR_LSB +: 7];
    // A byte count of 0 means 4096 bytes remaining.
    d[CC_BC_LSB +: 13]    = (bc == 12'd0) ? 13'd4096 : {1'b0, bc};
    d[CC_LOCKED_BIT]      = (hdr[LEG_TYPE_LSB +: 5] == TLP_TYPE_CPL_LK);
    d[CC_DWCNT_LSB +: 11] = cc_dword_count(hdr);
    d[CC_STATUS_LSB +: 3] = hdr[LEG_STATUS_LSB +: 3];
    d[CC_EP_BIT]          = hdr[LEG_EP_BIT];
    d[CC_RID_LSB +: 16]   = hdr[LEG_RID_LSB +: 16];
    d[CC_TAG_LSB +: 8]    = hdr[LEG_TAG_LSB +: 8];
    d[CC_CID_LO_LSB +: 8] = hdr[LEG_CID_LSB +: 8];
    d[CC_CID_HI_LSB +: 8] = hdr[LEG_CID_LSB + 8 +: 8];
    d[CC_TC_LSB +: 3]     = hdr[LEG_TC_LSB +: 3];
    d[CC_ATTR_LSB +: 3]   = {hdr[LEG_ATTR2_BIT], hdr[LEG_ATTR_LSB +: 2]};
    return d;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_skid_buf.sv
// ============================================================================
//  Module      : axis_skid_buf
//  Description : Fully registered AXI-stream skid buffer (main + spare).
//                One cycle latency, full throughput, registered in_ready_o.
//  Ports       : clk_i, rst_i (async, active high)
//                in_data_i/in_valid_i/in_ready_o   upstream side
//                out_data_o/out_valid_o/out_ready_i downstream side
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] main_data_q,  main_data_d;
  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] spare_data_q,  spare_data_d;
  logic             spare_valid_q, spare_valid_d;
  logic             ready_q, ready_d;
  logic             w_in_fire;

  // ready_q mirrors !spare_valid_q except straight after reset, where it is
  // held low for one cycle so every output starts at 0.
  assign w_in_fire = in_valid_i && ready_q;

  always_comb begin
    main_data_d   = main_data_q;
    main_valid_d  = main_valid_q;
    spare_data_d  = spare_data_q;
    spare_valid_d = spare_valid_q;
    if (!main_valid_q || out_ready_i) begin
      // Main register is free this cycle: refill from spare first so that
      // ordering is preserved, else take the incoming beat directly.
      if (spare_valid_q) begin
        main_data_d   = spare_data_q;
        main_valid_d  = 1'b1;
        spare_valid_d = 1'b0;
      end else if (w_in_fire) begin
        main_data_d  = in_data_i;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (w_in_fire) begin
      // Main is stalled: park the beat accepted on the previous ready.
      spare_data_d  = in_data_i;
      spare_valid_d = 1'b1;
    end
    ready_d = !spare_valid_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_data_q   <= '0;
      main_valid_q  <= 1'b0;
      spare_data_q  <= '0;
      spare_valid_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      main_data_q   <= main_data_d;
      main_valid_q  <= main_valid_d;
      spare_data_q  <= spare_data_d;
      spare_valid_q <= spare_valid_d;
      ready_q       <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_data_o  = main_data_q;
  assign out_valid_o = main_valid_q;

endmodule

`default_nettype wire

// File: rtl/s_axis_cc_adapt_x8.sv
// ============================================================================
//  Module      : s_axis_cc_adapt_x8
//  Description : Completer-completion adapter, UltraScale+ Gen3 x8, 256-bit.
//                Rewrites legacy 3DW completion headers into the 96-bit CC
//                descriptor, converts byte keep to dword keep, checks the
//                payload length and drives s_axis_cc through a skid buffer.
//  Options     : `define S_AXIS_CC_PARITY_EN  -> odd parity per output byte
//                on s_axis_cc_tuser_a[32:1]; otherwise those bits are 0.
//  Ports       : user_clk, user_reset (async, active high)
//                s_axis_cc_t*      legacy TLP input stream
//                s_axis_cc_t*_a    CC stream to the IP (tready_a[0] used)
//                cc_len_err        one-cycle pulse on payload length mismatch
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module s_axis_cc_adapt_x8 #(
  parameter int DATA_WIDTH = 256,  // only 256 is supported
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                      user_clk,
  input  logic                      user_reset,
  input  logic [DATA_WIDTH-1:0]     s_axis_cc_tdata,
  input  logic [KEEP_WIDTH-1:0]     s_axis_cc_tkeep,
  input  logic                      s_axis_cc_tlast,
  input  logic [3:0]                s_axis_cc_tuser,
  input  logic                      s_axis_cc_tvalid,
  output logic                      s_axis_cc_tready,
  output logic [DATA_WIDTH-1:0]     s_axis_cc_tdata_a,
  output logic [DATA_WIDTH/32-1:0]  s_axis_cc_tkeep_a,
  output logic                      s_axis_cc_tlast_a,
  output logic [32:0]               s_axis_cc_tuser_a,
  output logic                      s_axis_cc_tvalid_a,
  input  logic [3:0]                s_axis_cc_tready_a,
  output logic                      cc_len_err
);

  import litepcie_usp_pkg::*;

  localparam int DWK    = DATA_WIDTH / 32;
  localparam int USER_W = 33;
  localparam int BUF_W  = USER_W + 1 + DWK + DATA_WIDTH;

  logic [DWK-1:0]        w_keep_a;
  logic [DWK-1:0]        w_keep_unused;
  logic [3:0]            w_pop;
  logic [DATA_WIDTH-1:0] w_data;
  logic [10:0]           w_exp_dw;
  logic [10:0]           w_cnt_total;
  logic                  w_len_bad;
  logic                  w_disc;
  logic                  w_fire;
  logic [USER_W-1:0]     w_user;
  logic [BUF_W-1:0]      w_buf_in;
  logic [BUF_W-1:0]      w_buf_out;

  logic        sop_q, sop_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] exp_dw_q, exp_dw_d;
  logic        disc_q, disc_d;
  logic        len_err_q, len_err_d;

  // Keep is dword granular: the low byte enable of each dword stands for it.
  for (genvar gi = 0; gi < DWK; gi++) begin : g_keep
    assign w_keep_a[gi]      = s_axis_cc_tkeep[4*gi];
    assign w_keep_unused[gi] = ^s_axis_cc_tkeep[4*gi+1 +: 3];
  end

  assign w_pop  = popcount8(w_keep_a);
  assign w_fire = s_axis_cc_tvalid && s_axis_cc_tready;

  always_comb begin
    w_data = s_axis_cc_tdata;
    if (sop_q) begin
      w_data[95:0] = cc_build_desc(s_axis_cc_tdata[95:0]);
    end
  end

  // The expected count comes from the live header on a first beat so that
  // single-beat packets are checked on the same beat.
  assign w_exp_dw    = sop_q ? cc_dword_count(s_axis_cc_tdata[95:0]) : exp_dw_q;
  assign w_cnt_total = cnt_q + {7'd0, w_pop} - (sop_q ? LEG_HDR_DWORDS : 11'd0);
  assign w_len_bad   = (w_cnt_total != w_exp_dw);
  assign w_disc      = s_axis_cc_tlast && (disc_q || s_axis_cc_tuser[0] || w_len_bad);

  always_comb begin
    sop_d     = sop_q;
    cnt_d     = cnt_q;
    exp_dw_d  = exp_dw_q;
    disc_d    = disc_q;
    len_err_d = 1'b0;
    if (w_fire) begin
      if (s_axis_cc_tlast) begin
        sop_d     = 1'b1;
        cnt_d     = 11'd0;
        disc_d    = 1'b0;
        len_err_d = w_len_bad;
      end else begin
        sop_d  = 1'b0;
        cnt_d  = w_cnt_total;
        disc_d = disc_q || s_axis_cc_tuser[0];
        if (sop_q) begin
          exp_dw_d = w_exp_dw;
        end
      end
    end
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      sop_q     <= 1'b1;
      cnt_q     <= 11'd0;
      exp_dw_q  <= 11'd0;
      disc_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      sop_q     <= sop_d;
      cnt_q     <= cnt_d;
      exp_dw_q  <= exp_dw_d;
      disc_q    <= disc_d;
      len_err_q <= len_err_d;
    end
  end

`ifdef S_AXIS_CC_PARITY_EN
  // Odd parity: each byte plus its parity bit holds an odd number of ones.
  logic [KEEP_WIDTH-1:0] w_par;
  for (genvar gb = 0; gb < KEEP_WIDTH; gb++) begin : g_par
    assign w_par[gb] = ~^w_data[8*gb +: 8];
  end
  assign w_user = {w_par, w_disc};
`else
  assign w_user = {{(USER_W-1){1'b0}}, w_disc};
`endif

  assign w_buf_in = {w_user, s_axis_cc_tlast, w_keep_a, w_data};

  axis_skid_buf #(
    .WIDTH (BUF_W)
  ) u_skid (
    .clk_i       (user_clk),
    .rst_i       (user_reset),
    .in_data_i   (w_buf_in),
    .in_valid_i  (s_axis_cc_tvalid),
    .in_ready_o  (s_axis_cc_tready),
    .out_data_o  (w_buf_out),
    .out_valid_o (s_axis_cc_tvalid_a),
    .out_ready_i (s_axis_cc_tready_a[0])
  );

  assign {s_axis_cc_tuser_a, s_axis_cc_tlast_a, s_axis_cc_tkeep_a, s_axis_cc_tdata_a} = w_buf_out;
  assign cc_len_err = len_err_q;

  logic unused_ok;
  assign unused_ok = ^{s_axis_cc_tuser[3:1], s_axis_cc_tready_a[3:1], w_keep_unused};

endmodule

`default_nettype wire

// File: tb/tb_s_axis_cc_adapt_x8.sv
// ============================================================================
//  Module      : tb_s_axis_cc_adapt_x8
//  Description : Self-checking bench for s_axis_cc_adapt_x8. Packets are
//                described by their completion fields; the expected CC beats
//                are built from those fields and compared on every output
//                handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_s_axis_cc_adapt_x8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] tdata;
  logic [31:0]  tkeep;
  logic         tlast;
  logic [3:0]   tuser;
  logic         tvalid;
  logic         tready;
  logic [255:0] tdata_a;
  logic [7:0]   tkeep_a;
  logic         tlast_a;
  logic [32:0]  tuser_a;
  logic         tvalid_a;
  logic [3:0]   tready_a;
  logic         cc_len_err;

  always #5 clk = ~clk;

  s_axis_cc_adapt_x8 #(.DATA_WIDTH(256), .KEEP_WIDTH(32)) dut (
    .user_clk           (clk),
    .user_reset         (rst),
    .s_axis_cc_tdata    (tdata),
    .s_axis_cc_tkeep    (tkeep),
    .s_axis_cc_tlast    (tlast),
    .s_axis_cc_tuser    (tuser),
    .s_axis_cc_tvalid   (tvalid),
    .s_axis_cc_tready   (tready),
    .s_axis_cc_tdata_a  (tdata_a),
    .s_axis_cc_tkeep_a  (tkeep_a),
    .s_axis_cc_tlast_a  (tlast_a),
    .s_axis_cc_tuser_a  (tuser_a),
    .s_axis_cc_tvalid_a (tvalid_a),
    .s_axis_cc_tready_a (tready_a),
    .cc_len_err         (cc_len_err)
  );

  typedef struct { logic [255:0] d; logic [31:0] k; logic last; logic [3:0] u; } ibeat_t;
  typedef struct { logic [255:0] d; logic [7:0] k; logic last; logic disc; } obeat_t;

  ibeat_t in_q[$];
  obeat_t exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     exp_len_err = 0;
  int     obs_len_err = 0;
  bit     bp_en = 1'b0;

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic abort(input string tag);
    check(tag, 320'd1, 320'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  endtask

  // Build the legacy input beats and the expected CC beats of one packet.
  task automatic gen_pkt(input logic [2:0] fmt, input logic [4:0] typ, input logic [9:0] len,
                         input logic [11:0] bc, input logic [6:0] laddr, input logic [7:0] tag,
                         input logic [15:0] rid, input logic [15:0] cid, input logic [2:0] status,
                         input int n_pay, input int disc_beat);
    logic [31:0] h0, h1, h2;
    logic [95:0] desc;
    logic        ep, a2;
    logic [1:0]  attr;
    logic [2:0]  tc;
    int          expdw, total, nb, idx;
    bit          bad;
    ibeat_t      ib;
    obeat_t      ob;
    ep = 1'($urandom); a2 = 1'($urandom); attr = 2'($urandom); tc = 3'($urandom);
    h0 = $urandom; h0[31:29] = fmt; h0[28:24] = typ; h0[22:20] = tc; h0[18] = a2;
    h0[14] = ep; h0[13:12] = attr; h0[9:0] = len;
    h1 = $urandom; h1[11:0] = bc; h1[15:13] = status; h1[31:16] = cid;
    h2 = $urandom; h2[6:0] = laddr; h2[15:8] = tag; h2[31:16] = rid;
    expdw = fmt[1] ? ((len == 10'd0) ? 1024 : int'(len)) : 0;
    desc = '0;
    desc[6:0]   = laddr;
    desc[28:16] = (bc == 12'd0) ? 13'd4096 : 13'(bc);
    desc[29]    = (typ == 5'b01011);
    desc[42:32] = 11'(expdw);
    desc[45:43] = status;
    desc[46]    = ep;
    desc[63:48] = rid;
    desc[71:64] = tag;
    desc[87:72] = cid;
    desc[91:89] = tc;
    desc[94:92] = {a2, attr};
    total = 3 + n_pay;
    nb    = (total + 7) / 8;
    bad   = (n_pay != expdw);
    if (bad) exp_len_err++;
    for (int b = 0; b < nb; b++) begin
      for (int w = 0; w < 8; w++) ib.d[32*w +: 32] = $urandom;
      if (b == 0) ib.d[95:0] = {h2, h1, h0};
      ib.k = '0;
      ob.k = '0;
      for (int s = 0; s < 8; s++) begin
        idx = b * 8 + s;
        if (idx < total) begin
          ib.k[4*s +: 4] = 4'hF;
          ob.k[s] = 1'b1;
        end
      end
      ib.last = (b == nb - 1);
      ib.u    = 4'($urandom) & 4'hE;
      if (b == disc_beat) ib.u[0] = 1'b1;
      ob.d = ib.d;
      if (b == 0) ob.d[95:0] = desc;
      ob.last = ib.last;
      ob.disc = ib.last && (bad || (disc_beat >= 0 && disc_beat < nb));
      in_q.push_back(ib);
      exp_q.push_back(ob);
    end
  endtask

  task automatic drive_beat(input ibeat_t b);
    tdata = b.d; tkeep = b.k; tlast = b.last; tuser = b.u; tvalid = 1'b1;
  endtask

  task automatic send_beat(input ibeat_t b);
    int t;
    drive_beat(b);
    t = 0;
    @(negedge clk);
    while (!tready) begin
      t++;
      if (t > 1000) abort("tready_timeout");
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input int idle_pct);
    ibeat_t b;
    while (in_q.size() > 0) begin
      b = in_q.pop_front();
      while ($urandom_range(99) < idle_pct) begin
        tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_beat(b);
    end
    tvalid = 1'b0;
  endtask

  task automatic drain;
    int t;
    t = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk);
      t++;
      if (t > 5000) abort("drain_timeout");
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_parity(input logic [255:0] d);
    logic [31:0] p;
    p = '0;
`ifdef S_AXIS_CC_PARITY_EN
    for (int i = 0; i < 32; i++) p[i] = ~^d[8*i +: 8];
`endif
    return p;
  endfunction

  // Ready toggling on the IP side; bits [3:1] are always random.
  initial begin
    tready_a = 4'hF;
    forever begin
      @(posedge clk);
      #1;
      tready_a = {3'($urandom), bp_en ? 1'($urandom) : 1'b1};
    end
  end

  // Output monitor: scoreboard compare on each handshake, hold check on stall.
  logic         held_v = 1'b0;
  logic [299:0] held;
  always @(negedge clk) begin
    obeat_t e;
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (cc_len_err) obs_len_err++;
      if (held_v) check("hold_stable", {tvalid_a, tuser_a, tlast_a, tkeep_a, tdata_a}, held);
      held_v = 1'b0;
      if (tvalid_a) begin
        if (tready_a[0]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 320'd1, 320'd0);
          end else begin
            e = exp_q.pop_front();
            check("tdata_a", tdata_a, e.d);
            check("tkeep_a", tkeep_a, e.k);
            check("tlast_a", tlast_a, e.last);
            check("discontinue", tuser_a[0], e.disc);
            check("parity", tuser_a[32:1], exp_parity(e.d));
          end
        end else begin
          held_v = 1'b1;
          held   = {tvalid_a, tuser_a, tlast_a, tkeep_a, tdata_a};
        end
      end
    end
  end

  initial begin
    #300000;
    abort("global_timeout");
  end

  initial begin
    ibeat_t      b;
    logic [2:0]  fmt;
    logic [4:0]  typ;
    logic [9:0]  len;
    logic [11:0] bc;
    logic [2:0]  st;
    int          n_pay, nb, disc;
    tdata = '0; tkeep = '0; tlast = 1'b0; tuser = '0; tvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {tready, tvalid_a, tlast_a, tkeep_a, tuser_a, cc_len_err, tdata_a}, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single-beat CplD.
    gen_pkt(3'b010, 5'b01010, 10'd1, 12'd4, 7'h04, 8'h12, 16'h0100, 16'h0200, 3'b000, 1, -1);
    drive_all(0); drain();
    // Three-beat CplD, 16 dwords.
    gen_pkt(3'b010, 5'b01010, 10'd16, 12'd64, 7'h00, 8'h34, 16'h0101, 16'h0201, 3'b000, 16, -1);
    drive_all(0); drain();
    // No-data Cpl with UR and bc=0; the length field must be ignored.
    gen_pkt(3'b000, 5'b01010, 10'd5, 12'd0, 7'h10, 8'h56, 16'h0102, 16'h0202, 3'b001, 0, -1);
    drive_all(0); drain();
    // Announced 8 dwords, only 4 sent, then a clean packet.
    gen_pkt(3'b010, 5'b01011, 10'd8, 12'd32, 7'h08, 8'h78, 16'h0103, 16'h0203, 3'b000, 4, -1);
    gen_pkt(3'b010, 5'b01010, 10'd2, 12'd8, 7'h0C, 8'h79, 16'h0104, 16'h0204, 3'b000, 2, -1);
    drive_all(0); drain();
    check("len_err_directed", obs_len_err, exp_len_err);

    // Randomized packets under 50% backpressure and input gaps.
    bp_en = 1'b1;
    for (int p = 0; p < 100; p++) begin
      fmt = ($urandom_range(3) == 0) ? 3'b000 : 3'b010;
      typ = $urandom_range(1) ? 5'b01011 : 5'b01010;
      len = 10'($urandom_range(1, 24));
      bc  = ($urandom_range(9) == 0) ? 12'd0 : 12'($urandom);
      case ($urandom_range(3))
        0: st = 3'b000;
        1: st = 3'b001;
        2: st = 3'b010;
        default: st = 3'b100;
      endcase
      if (fmt[1]) n_pay = ($urandom_range(9) == 0) ? int'($urandom_range(24)) : int'(len);
      else        n_pay = ($urandom_range(9) == 0) ? int'($urandom_range(1, 4)) : 0;
      nb   = (3 + n_pay + 7) / 8;
      disc = ($urandom_range(9) == 0) ? int'($urandom_range(nb - 1)) : -1;
      gen_pkt(fmt, typ, len, bc, 7'($urandom), 8'($urandom), 16'($urandom), 16'($urandom),
              st, n_pay, disc);
    end
    drive_all(25); drain();
    check("len_err_random", obs_len_err, exp_len_err);

    // Reset on beat 2 of a 3-beat packet.
    bp_en = 1'b0;
    @(posedge clk);
    #1;
    gen_pkt(3'b010, 5'b01010, 10'd16, 12'd64, 7'h00, 8'h9A, 16'h0105, 16'h0205, 3'b000, 16, -1);
    b = in_q.pop_front();
    send_beat(b);
    b = in_q.pop_front();
    drive_beat(b);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("reset_midpkt", {tready, tvalid_a, tlast_a, tkeep_a, tuser_a, cc_len_err, tdata_a}, '0);
    tvalid = 1'b0;
    repeat (3) @(negedge clk);
    in_q.delete();
    exp_q.delete();
    rst = 1'b0;
    @(posedge clk);
    #1;
    gen_pkt(3'b010, 5'b01010, 10'd1, 12'd4, 7'h24, 8'hBC, 16'h0106, 16'h0206, 3'b000, 1, -1);
    drive_all(0); drain();
    check("len_err_total", obs_len_err, exp_len_err);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
